// File: rtl/serial_pattern_scanner_if.sv
// Word handshake between a producer and the serial pattern scanner.
interface serial_pattern_scanner_if #(
    parameter int WORD_W = 8
);
    logic              In_Valid;
    logic              In_Ready;
    logic [WORD_W-1:0] In_Data;

    modport master (
        output In_Valid,
        output In_Data,
        input  In_Ready
    );

    modport slave (
        input  In_Valid,
        input  In_Data,
        output In_Ready
    );
endinterface

// File: rtl/serial_pattern_scanner.sv
// Serialises words MSB-first into a programmable pattern matcher.
// History persists across words so boundary-spanning matches are seen.
module serial_pattern_scanner #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    serial_pattern_scanner_if.slave in_if,
    input  logic                    Cfg_We,
    input  logic [PAT_W-1:0]        Cfg_Pattern,
    input  logic [$clog2(PAT_W):0]  Cfg_Len,
    output logic                    Busy,
    output logic                    Ser_Bit,
    output logic                    Match,
    output logic [CNT_W-1:0]        Match_Count,
    output logic                    Done
);
    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam int IDX_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic              ready;
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [PAT_W-1:0]  hist;
    logic [LEN_W-1:0]  fill;
    logic [PAT_W-1:0]  cfg_pat;
    logic [LEN_W-1:0]  cfg_len;

    logic [PAT_W:0]    hist_ext;
    logic [PAT_W-1:0]  hist_nx;
    logic [LEN_W-1:0]  fill_nx;
    logic [PAT_W-1:0]  mask;
    logic [LEN_W-1:0]  len_clamp;
    logic              hit;

    assign in_if.In_Ready = ready;

    always_comb begin
        len_clamp = (Cfg_Len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : Cfg_Len;
        hist_ext  = {hist, Ser_Bit};
        hist_nx   = hist_ext[PAT_W-1:0];
        fill_nx   = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
        mask      = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(cfg_len));
        end
        // Compare only the low Len bits of the post-shift history.
        hit = (cfg_len != '0) && (fill_nx >= cfg_len) &&
              (((hist_nx ^ cfg_pat) & mask) == '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            Busy        <= 1'b0;
            Ser_Bit     <= 1'b0;
            Match       <= 1'b0;
            Done        <= 1'b0;
            Match_Count <= '0;
            word        <= '0;
            idx         <= '0;
            hist        <= '0;
            fill        <= '0;
            cfg_pat     <= '0;
            cfg_len     <= '0;
        end else begin
            Match <= 1'b0;
            Done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Cfg_We) begin
                        cfg_pat <= Cfg_Pattern;
                        cfg_len <= len_clamp;
                        hist    <= '0;
                        fill    <= '0;
                    end
                    if (in_if.In_Valid) begin
                        word        <= in_if.In_Data;
                        Ser_Bit     <= in_if.In_Data[WORD_W-1];
                        idx         <= IDX_W'(WORD_W - 1);
                        Match_Count <= '0;
                        ready       <= 1'b0;
                        Busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    hist <= hist_nx;
                    fill <= fill_nx;
                    if (hit) begin
                        Match <= 1'b1;
                        if (Match_Count != '1) begin
                            Match_Count <= Match_Count + 1'b1;
                        end
                    end
                    if (idx == '0) begin
                        Ser_Bit <= 1'b0;
                        Done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        Ser_Bit <= word[idx - 1'b1];
                        idx     <= idx - 1'b1;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pattern_scanner.sv
// Directed bench for serial_pattern_scanner (WORD_W=8, PAT_W=4, CNT_W=2).
module tb_serial_pattern_scanner;
    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 2;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Cfg_We;
    logic [PAT_W-1:0] Cfg_Pattern;
    logic [2:0]       Cfg_Len;
    logic             Busy;
    logic             Ser_Bit;
    logic             Match;
    logic [CNT_W-1:0] Match_Count;
    logic             Done;

    int checks = 0;
    int errors = 0;

    serial_pattern_scanner_if #(.WORD_W(WORD_W)) bus ();

    serial_pattern_scanner #(
        .WORD_W(WORD_W),
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .in_if      (bus.slave),
        .Cfg_We     (Cfg_We),
        .Cfg_Pattern(Cfg_Pattern),
        .Cfg_Len    (Cfg_Len),
        .Busy       (Busy),
        .Ser_Bit    (Ser_Bit),
        .Match      (Match),
        .Match_Count(Match_Count),
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit         do_cfg;
        logic [3:0] pat;
        logic [2:0] len;
        logic [7:0] data;
        bit         mid_we;
        logic [7:0] exp_match;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Accept one word (optionally with a config write on the same cycle),
    // then check every cycle of SHIFT and DONE plus the following IDLE.
    task automatic scan(input vec_t v, input int id);
        int em;
        @(negedge Clk);
        chk($sformatf("v%0d idle_ready", id), int'(bus.In_Ready), 1);
        if (v.do_cfg) begin
            Cfg_We      = 1'b1;
            Cfg_Pattern = v.pat;
            Cfg_Len     = v.len;
        end
        bus.In_Valid = 1'b1;
        bus.In_Data  = v.data;
        @(posedge Clk);
        #1;
        bus.In_Valid = 1'b0;
        Cfg_We       = 1'b0;
        bus.In_Data  = ~v.data;
        for (int c = 1; c <= 9; c++) begin
            @(negedge Clk);
            em = (c >= 2) ? int'(v.exp_match[9-c]) : 0;
            chk($sformatf("v%0d c%0d match", id, c), int'(Match), em);
            chk($sformatf("v%0d c%0d busy_rdy", id, c),
                int'({Busy, bus.In_Ready}), 2);
            if (c <= 8) begin
                chk($sformatf("v%0d c%0d ser", id, c),
                    int'(Ser_Bit), int'(v.data[8-c]));
                chk($sformatf("v%0d c%0d done", id, c), int'(Done), 0);
            end else begin
                chk($sformatf("v%0d done", id), int'(Done), 1);
                chk($sformatf("v%0d count", id), int'(Match_Count), v.exp_cnt);
            end
            if (v.mid_we && c == 3) begin
                Cfg_We      = 1'b1;
                Cfg_Len     = 3'd2;
                Cfg_Pattern = 4'b0011;
            end
            if (c == 4) Cfg_We = 1'b0;
        end
        @(negedge Clk);
        chk($sformatf("v%0d post_done", id), int'(Done), 0);
        chk($sformatf("v%0d post_ready", id), int'(bus.In_Ready), 1);
        chk($sformatf("v%0d post_busy", id), int'(Busy), 0);
        chk($sformatf("v%0d count_hold", id), int'(Match_Count), v.exp_cnt);
    endtask

    initial begin
        int   a1, a2, lowcnt, bad_busy, seen_done;
        vec_t rv;

        vecs[0] = '{1, 4'b0101, 3'd3, 8'b10101000, 0, 8'b00101000, 2};
        vecs[1] = '{0, 4'b0000, 3'd0, 8'b00000010, 0, 8'b00000000, 0};
        vecs[2] = '{0, 4'b0000, 3'd0, 8'b10000000, 0, 8'b10000000, 1};
        vecs[3] = '{1, 4'b0001, 3'd1, 8'hFF,       0, 8'hFF,       3};
        vecs[4] = '{1, 4'b0001, 3'd1, 8'h12,       0, 8'h12,       2};
        vecs[5] = '{1, 4'b0001, 3'd0, 8'hFF,       0, 8'h00,       0};
        vecs[6] = '{1, 4'b1111, 3'd7, 8'hFF,       0, 8'b00011111, 3};
        vecs[7] = '{1, 4'b0110, 3'd4, 8'b01101101, 0, 8'b00010010, 2};
        vecs[8] = '{1, 4'b0101, 3'd3, 8'b10101001, 1, 8'b00101000, 2};
        vecs[9] = '{1, 4'b0011, 3'd2, 8'b11000000, 0, 8'b01000000, 1};

        Reset        = 1'b1;
        Cfg_We       = 1'b0;
        Cfg_Pattern  = '0;
        Cfg_Len      = '0;
        bus.In_Valid = 1'b0;
        bus.In_Data  = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst ready", int'(bus.In_Ready), 1);
        chk("rst busy", int'(Busy), 0);
        chk("rst ser", int'(Ser_Bit), 0);
        chk("rst match", int'(Match), 0);
        chk("rst done", int'(Done), 0);
        chk("rst count", int'(Match_Count), 0);
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            scan(vecs[i], i);
        end

        // Reset in the 4th SHIFT cycle discards the word, no Done.
        @(negedge Clk);
        Cfg_We       = 1'b1;
        Cfg_Pattern  = 4'b0101;
        Cfg_Len      = 3'd3;
        bus.In_Valid = 1'b1;
        bus.In_Data  = 8'hFF;
        @(posedge Clk);
        #1;
        Cfg_We       = 1'b0;
        bus.In_Valid = 1'b0;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("mid_rst ready", int'(bus.In_Ready), 1);
        chk("mid_rst busy", int'(Busy), 0);
        chk("mid_rst count", int'(Match_Count), 0);
        chk("mid_rst done", int'(Done), 0);
        seen_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge Clk);
            if (Done) seen_done++;
        end
        chk("mid_rst no_done", seen_done, 0);
        rv = '{0, 4'b0000, 3'd0, 8'hFF, 0, 8'h00, 0};
        scan(rv, 10);

        // Back-to-back words with In_Valid held high.
        a1 = -1;
        a2 = -1;
        lowcnt = 0;
        bad_busy = 0;
        @(negedge Clk);
        bus.In_Valid = 1'b1;
        bus.In_Data  = 8'h5A;
        for (int n = 0; n < 40; n++) begin
            if (Busy == bus.In_Ready) bad_busy++;
            if (bus.In_Ready) begin
                if (a1 < 0) a1 = n;
                else a2 = n;
            end else if (a1 >= 0) begin
                lowcnt++;
            end
            if (a2 >= 0) begin
                bus.In_Valid = 1'b0;
                break;
            end
            @(negedge Clk);
        end
        bus.In_Valid = 1'b0;
        chk("tput second_accept_seen", int'(a2 >= 0), 1);
        chk("tput accept_gap", a2 - a1, 10);
        chk("tput ready_low_cycles", lowcnt, 9);
        chk("tput busy_inverse", bad_busy, 0);
        a1 = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (n > 0 && bus.In_Ready) begin
                a1 = 1;
                break;
            end
        end
        chk("tput return_idle", a1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_pattern_scanner.md
Name: serial_pattern_scanner

Overview:
- Controller that sequences a serial pattern-detection datapath. It accepts parallel words over a valid/ready handshake and serialises each word MSB-first, one bit per clock, into a programmable-pattern match shift register.
- It counts matches per word and reports completion with a one-cycle Done pulse.
- It sits between a word-oriented producer and the serial detection logic. Pattern history runs continuously across words, so matches that span word boundaries are found.

Parameters:
WORD_W, 8, bits per input word (>=2)
PAT_W, 4, maximum pattern length in bits (>=1)
CNT_W, 4, width of per-word match counter (saturating)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Cfg_We  input  1  config write strobe; honoured only in IDLE
Cfg_Pattern  input  PAT_W  pattern; bit [Len-1] is compared against the oldest bit, bit 0 against the newest
Cfg_Len  input  $clog2(PAT_W)+1  active pattern length; 0 = matching disabled; >PAT_W clamped to PAT_W
In_Valid  input  1  producer has a word
In_Ready  output  1  block can accept a word
In_Data  input  WORD_W  word to scan, MSB shifted first
Busy  output  1  high in SHIFT and DONE
Ser_Bit  output  1  bit being consumed this cycle (debug/observe)
Match  output  1  registered pulse, one per detected match
Match_Count  output  CNT_W  matches in current/last word
Done  output  1  one-cycle pulse at end of word

Behaviour:
- Interface: single clock Clk; Reset is synchronous and active-high.
- Reset values: state=IDLE, In_Ready=1, Busy=0, Ser_Bit=0, Match=0, Done=0, Match_Count=0.
- Reset also clears the word register, history, fill counter, Cfg pattern (0) and Cfg length (0).
- Reset has priority over all other inputs, including mid-word. The partial word is discarded and Done is not pulsed.
- States:
  - IDLE: In_Ready=1. Cfg_We=1 latches Cfg_Pattern and clamped Cfg_Len, and clears history and fill.
  - IDLE, handshake: In_Valid&In_Ready captures In_Data, clears Match_Count, resets the bit index to WORD_W-1, and moves to SHIFT next cycle.
  - IDLE, simultaneous Cfg_We and accept: the config is applied first, so the new word scans with the new pattern from empty history.
  - SHIFT: lasts exactly WORD_W cycles. Each cycle, Ser_Bit = word[idx]. At the clock edge the history shifts left with Ser_Bit entering at bit 0, fill increments (saturating at PAT_W), and idx decrements. After idx=0 the state moves to DONE. In_Ready=0. Cfg_We is ignored.
  - DONE: one cycle. Done=1, In_Ready=0. Returns to IDLE.
- Match rule:
  - Evaluated each SHIFT cycle on the post-shift history, using the low Len bits.
  - A hit requires Len!=0, fill (including the current bit) >= Len, and history[Len-1:0] == pattern[Len-1:0].
  - Match is registered and is high in the cycle after the qualifying bit. The last bit of a word therefore reports Match in the DONE cycle.
  - Match_Count increments in the same cycle Match rises, saturating at 2^CNT_W-1. It is final and stable when Done=1, and holds until the next accept.
- Overlapping matches are counted. History and fill persist across words; only Reset and Cfg_We clear them.
- Throughput: one word per WORD_W+2 cycles with In_Valid held high (accept in IDLE, WORD_W SHIFT cycles, DONE).
- In_Data is sampled only at the handshake. Changes to In_Data during SHIFT have no effect.

Test Plan:
- Cfg pattern 4'b0101, Len 3 ("101"); word 8'b10101000 -> Match pulses in the cycles after bits 3 and 5 (1-based). Done at cycle WORD_W+1 after the accept cycle; Match_Count=2.
- Same config; word 8'b00000010, then word 8'b10000000 -> word 1 count 0; word 2 Match one cycle after its first bit, count 1 (cross-word match).
- Len 1, pattern 1, CNT_W=2; word 8'hFF -> Match high for 8 consecutive cycles; Match_Count saturates at 3 at Done.
- Cfg_We with Len 2 pattern "11" asserted during SHIFT -> ignored; counts follow the old pattern. The same write in IDLE clears history: next word 8'b1xxxxxxx with "1" bit first gives no match on bit 1 (fill<2).
- Reset asserted on 4th SHIFT cycle -> next cycle IDLE, In_Ready=1, Match_Count=0, no Done pulse. The next word scans with Len=0, so no matches.
- In_Valid held high with two words -> In_Ready low for WORD_W+1 cycles between accepts. Accepts are exactly 10 cycles apart for WORD_W=8. Busy is the inverse of In_Ready.
